// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low {g,f,e,d,c,b,a} glyphs for BCD digits.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Anodes are active-low, so "all off" is all ones at whatever digit count the user picks.
  localparam logic ANODE_OFF_BIT = 1'b1;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank the digit.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display scanner with dead-time blanking, edit blink and colon.
// All state advances on the falling edge of MCLK.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 16384,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BLINK_DIV    = 8388608,
  parameter int unsigned DP_POS       = 2
) (
  input  logic                    MCLK,
  input  logic                    resetSignal,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    clkin,
  input  logic                    stopSignal,
  input  logic [1:0]              editSel,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] AnodeOff = {NUM_DIGITS{ANODE_OFF_BIT}};

  logic [CntW-1:0]       refresh_cnt_q, refresh_cnt_d;
  logic [IdxW-1:0]       scan_idx_q, scan_idx_d;
  logic [BlkW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [3:0]            snapshot_q, snapshot_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [6:0] seg_dec;
  logic [3:0] digit_sel;
  logic       refresh_wrap, blink_wrap, edit_match, blank_now, colon_on;

  seg7_decoder u_decoder (
    .bcd_i (snapshot_q),
    .seg_o (seg_dec)
  );

  always_comb begin
    refresh_wrap  = (refresh_cnt_q == CntW'(REFRESH_DIV - 1));
    refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
    scan_idx_d    = scan_idx_q;
    if (refresh_wrap) begin
      scan_idx_d = (scan_idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end

    blink_wrap    = (blink_cnt_q == BlkW'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;

    // editSel values beyond the scanned range simply never match.
    edit_match = (32'(editSel) == 32'(scan_idx_q));
    blank_now  = (refresh_cnt_q < CntW'(BLANK_CYCLES)) ||
                 (!stopSignal && edit_match && blink_phase_q);

    digit_sel = 4'h0;
    anode_d   = AnodeOff;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IdxW'(i)) begin
        digit_sel  = digits[4*i +: 4];
        anode_d[i] = blank_now;
      end
    end

    // Latch the slot's digit once so mid-slot input changes cannot tear the display.
    snapshot_d = (refresh_cnt_q == '0) ? digit_sel : snapshot_q;

    seg_d    = seg_dec;
    colon_on = stopSignal ? clkin : 1'b1;
    dp_d     = ~(colon_on && (scan_idx_q == IdxW'(DP_POS)) && !blank_now);
  end

  always_ff @(negedge MCLK or negedge resetSignal) begin
    if (!resetSignal) begin
      refresh_cnt_q <= '0;
      scan_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snapshot_q    <= 4'h0;
      anode_q       <= AnodeOff;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snapshot_q    <= snapshot_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule
